// File: rtl/gshare_bht.sv
// gshare branch history table: 2-bit saturating-style counters indexed by PC XOR global history.
// Registered prediction one cycle after lookup; counters and history train at resolve time.
module gshare_bht #(
   parameter int INDEX_BITS = 4,
   parameter int HIST_BITS  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  lookup_valid,
   input  logic [31:0]           lookup_pc,
   output logic                  pred_valid,
   output logic                  prediction,
   output logic [INDEX_BITS-1:0] pred_index,
   input  logic                  update_valid,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  update_taken,
   output logic [HIST_BITS-1:0]  ghr
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            counters [ENTRIES];
   logic [INDEX_BITS-1:0] idx;
   logic [HIST_BITS-1:0]  ghr_next;
   logic                  unused_pc_bits;

   // Weak states jump straight to the strong state of the observed direction.
   function automatic logic [1:0] train(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      case (cnt)
         2'b00:   nxt = taken ? 2'b01 : 2'b00;
         2'b11:   nxt = taken ? 2'b11 : 2'b10;
         default: nxt = taken ? 2'b11 : 2'b00;
      endcase
      return nxt;
   endfunction

   assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

   // Uses the history before any same-cycle update (read-before-write).
   assign idx = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);

   generate
      if (HIST_BITS == 1) begin : g_hist_one
         assign ghr_next = update_taken;
      end else begin : g_hist_shift
         assign ghr_next = {ghr[HIST_BITS-2:0], update_taken};
      end
   endgenerate

   // NOTE: the table must come out of reset at weakly-not-taken, so it is built
   // from resettable flops rather than an inferred RAM that cannot be cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) counters[i] <= 2'b01;
      end else if (update_valid) begin
         counters[update_index] <= train(counters[update_index], update_taken);
      end
   end

   // NOTE: all state uses non-blocking assignments so the lookup below sees the
   // pre-update counter and history even when both happen in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ghr        <= '0;
         pred_valid <= 1'b0;
         prediction <= 1'b0;
         pred_index <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_index <= idx;
            prediction <= counters[idx][1];
         end
         if (update_valid) ghr <= ghr_next;
      end
   end

endmodule
